// File: rtl/alu_issue_ctrl_pkg.sv
// Shared constants for the ALU issue controller: funct/opcode codes,
// instruction field positions and the FSM state encoding.
package alu_issue_ctrl_pkg;

  localparam logic [5:0] F_ADD = 6'd0;
  localparam logic [5:0] F_SUB = 6'd1;
  localparam logic [5:0] F_AND = 6'd2;
  localparam logic [5:0] F_OR  = 6'd3;
  localparam logic [5:0] F_XOR = 6'd4;
  localparam logic [5:0] F_NOT = 6'd5;
  localparam logic [5:0] F_SLA = 6'd6;
  localparam logic [5:0] F_SRA = 6'd7;
  localparam logic [5:0] F_SRL = 6'd8;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_ADDI  = 6'd1;

  localparam int OP_LO  = 26;
  localparam int RS_LO  = 22;
  localparam int RT_LO  = 18;
  localparam int RD_LO  = 14;
  localparam int SH_LO  = 6;
  localparam int FN_LO  = 0;
  localparam int IMM_LO = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_e;

  function automatic logic funct_legal(
    input logic [5:0] f
  );
    return f <= F_SRL;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_decode.sv
// Combinational instruction decode: field extraction, imm sign-extension
// and legality. Ports: instr_i in; rs/rt/rd, shamt, funct, imm, is_imm, legal out.
module instr_decode
  import alu_issue_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
) (
  input  logic [31:0]       instr_i,
  output logic [REG_AW-1:0] rs_o,
  output logic [REG_AW-1:0] rt_o,
  output logic [REG_AW-1:0] rd_o,
  output logic [4:0]        shamt_o,
  output logic [5:0]        funct_o,
  output logic [DATA_W-1:0] imm_o,
  output logic              is_imm_o,
  output logic              legal_o
);

  logic [5:0] op;
  logic       is_r;
  logic       unused_bits;

  assign op       = instr_i[OP_LO +: 6];
  assign is_r     = (op == OP_RTYPE);
  assign is_imm_o = (op == OP_ADDI);

  assign rs_o = instr_i[RS_LO +: REG_AW];
  assign rt_o = instr_i[RT_LO +: REG_AW];

  // ADDI places its destination in the rt slot
  assign rd_o = is_imm_o ? instr_i[RT_LO +: REG_AW]
                         : instr_i[RD_LO +: REG_AW];

  assign shamt_o = is_imm_o ? 5'd0 : instr_i[SH_LO +: 5];
  assign funct_o = is_imm_o ? F_ADD : instr_i[FN_LO +: 6];

  assign imm_o = {{(DATA_W-16){instr_i[15]}},
                  instr_i[IMM_LO +: 16]};

  assign legal_o = is_imm_o
                 | (is_r & funct_legal(instr_i[FN_LO +: 6]));

  assign unused_bits = ^instr_i[13:11];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one decoded instruction at a time to a clocked ALU and writes
// the result back. Ports: in_* handshake, rs/rt read, alu_* drive, wb_*, done, err.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  output logic [REG_AW-1:0] rs_addr,
  output logic [REG_AW-1:0] rt_addr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [4:0]        alu_shamt,
  output logic [5:0]        alu_funct,
  input  logic [DATA_W-1:0] alu_res,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              done,
  output logic              err
);

  state_e state_q, state_d;

  logic [31:0]       instr_q, instr_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [4:0]        sh_q, sh_d;
  logic [5:0]        fn_q, fn_d;
  logic              err_q, err_d;

  logic [REG_AW-1:0] d_rs, d_rt, d_rd;
  logic [4:0]        d_sh;
  logic [5:0]        d_fn;
  logic [DATA_W-1:0] d_imm;
  logic              d_is_imm;
  logic              d_legal;

  logic [DATA_W-1:0] op_a, op_b;

  instr_decode #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_dec (
    .instr_i  (instr_q),
    .rs_o     (d_rs),
    .rt_o     (d_rt),
    .rd_o     (d_rd),
    .shamt_o  (d_sh),
    .funct_o  (d_fn),
    .imm_o    (d_imm),
    .is_imm_o (d_is_imm),
    .legal_o  (d_legal)
  );

  // r0 is hard zero regardless of what the bank returns
  assign op_a = (d_rs == '0) ? '0 : rs_data;
  assign op_b = d_is_imm      ? d_imm
              : (d_rt == '0)  ? '0
              :                 rt_data;

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    a_d      = a_q;
    b_d      = b_q;
    sh_d     = sh_q;
    fn_d     = fn_q;
    err_d    = 1'b0;
    in_ready = 1'b0;
    rs_addr  = '0;
    rt_addr  = '0;
    wb_en    = 1'b0;
    wb_addr  = '0;
    wb_data  = '0;
    done     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          instr_d = in_instr;
          state_d = S_READ;
        end
      end
      S_READ: begin
        rs_addr = d_rs;
        rt_addr = d_rt;
        if (d_legal) begin
          a_d     = op_a;
          b_d     = op_b;
          sh_d    = d_sh;
          fn_d    = d_fn;
          state_d = S_EXEC;
        end else begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        state_d = S_WB;
      end
      S_WB: begin
        wb_en   = (d_rd != '0);
        wb_addr = d_rd;
        wb_data = alu_res;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      fn_q    <= F_ADD;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sh_q    <= sh_d;
      fn_q    <= fn_d;
      err_q   <= err_d;
    end
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_shamt = sh_q;
  assign alu_funct = fn_q;
  assign err       = err_q;

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Initiator side of the ALU operand/funct interface. Accepts one instruction word per valid/ready handshake, decodes it, reads source operands from the register bank, and drives a/b/shamt/funct to the clocked ALU.
- Captures the ALU's registered result one cycle later and issues a single register-bank write-back.
- Sits between instruction fetch and the ALU/regbank pair. One instruction in flight; no pipelining.

Parameters:
- DATA_W, 32, operand/result width.
- REG_AW, 4, register-bank address width (16 registers; r0 reads as zero and is never written).

Ports:
- clk  in  1  single clock, all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  block can accept (high only in IDLE).
- in_instr  in  32  instruction word.
- rs_addr  out  REG_AW  regbank read port A address.
- rt_addr  out  REG_AW  regbank read port B address.
- rs_data  in  DATA_W  combinational read data A.
- rt_data  in  DATA_W  combinational read data B.
- alu_a  out  DATA_W  ALU operand a (registered).
- alu_b  out  DATA_W  ALU operand b (registered).
- alu_shamt  out  5  ALU shift amount (registered).
- alu_funct  out  6  ALU function code (registered).
- alu_res  in  DATA_W  ALU result (ALU registers it on posedge).
- wb_en  out  1  regbank write strobe.
- wb_addr  out  REG_AW  write-back register.
- wb_data  out  DATA_W  write-back value.
- done  out  1  one-cycle pulse: instruction retired.
- err  out  1  one-cycle pulse: illegal instruction dropped.

Behaviour:
- Instruction formats:
  - R-type: opcode [31:26]=0, rs [25:22], rt [21:18], rd [17:14], shamt [10:6], funct [5:0].
  - ADDI: opcode=1, rs [25:22], rd [21:18], imm [15:0] sign-extended to DATA_W; issued as funct ADD with b=imm.
- Funct codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, NOT 5, SLA 6, SRA 7, SRL 8. Any other funct, or any opcode other than 0/1, is illegal.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid, latch in_instr and go to READ.
  - READ: rs_addr/rt_addr driven from the latched word. If the word is legal, register rs_data (or r0 → 0) into alu_a, rt_data or sign-extended imm into alu_b, plus shamt and funct, then go to EXEC. If illegal, go to IDLE with err=1 for that first IDLE cycle; no ALU or regbank activity.
  - EXEC: alu_* held stable. The ALU samples them on the closing edge.
  - WB: wb_en=1 (0 if rd=0), wb_addr=rd, wb_data=alu_res, done=1. Next state is IDLE.
- Latency: handshake edge to the WB cycle is 3 cycles. Throughput is 1 instruction per 4 cycles.
- rs_addr/rt_addr are 0 outside READ. wb_en, done and err are low except in the cycles described above.
- alu_a/alu_b/alu_shamt/alu_funct hold their last value in IDLE, so the ALU keeps recomputing the same op. This is harmless because no write-back occurs.
- Reset values: in_ready=1 (state IDLE), alu_a=0, alu_b=0, alu_shamt=0, alu_funct=ADD(0), wb_en=0, wb_addr=0, wb_data=0, done=0, err=0.
- Reset asserted in any state returns to IDLE on that edge. The in-flight instruction is discarded and no wb_en or done is produced.
- in_valid in a non-IDLE state is ignored (in_ready=0). The upstream must hold it.
- Reading r0 on either port yields 0 regardless of rs_data/rt_data.

Decomposition:
- Shared package: funct constants (ADD..SRL), opcode constants (OP_RTYPE=0, OP_ADDI=1), instruction field bit positions, FSM state encoding.
- One natural sub-module, instr_decode: combinational field extraction, sign-extension and legality check. The FSM and registers stay in alu_issue_ctrl.

Test Plan:
- R-type ADD r3=r1+r2 with r1=5, r2=7 → wb_en, wb_addr=3, wb_data=12, done exactly 3 cycles after the accept edge.
- ADDI r4=r1+0xFFFF with r1=5 → alu_b=0xFFFFFFFF, wb_data=4.
- SRL, funct 8, shamt 4, rs=0xF0000000 → alu_funct=8, alu_shamt=4 held through EXEC. Two back-to-back in_valid: second accepted only when in_ready returns, 4 cycles apart.
- Illegal funct 9 and opcode 5 → err one cycle, no wb_en, no done, in_ready=1 on the err cycle.
- Write to rd=0 → done=1, wb_en=0. Read of r0 with rs_data=0xDEADBEEF forced → alu_a=0.
- rst asserted during EXEC → next cycle IDLE, in_ready=1, no wb_en/done. All outputs match the reset values above.
